// File: rtl/dekatron_pkg.sv
// Shared types and helpers for the chained dekatron counter.
// Holds the step FSM encoding, direction constants and the glow-position
// <-> main-cathode one-hot conversions (sized for the largest legal tube).
package dekatron_pkg;

    localparam int unsigned MAX_DIGITS = 16;
    localparam int unsigned MAX_POS_W  = 6;

    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G1   = 2'd1,
        G2   = 2'd2,
        LAND = 2'd3
    } dek_state_e;

    // Main cathode n sits at position 3n; guide positions decode to all-zero.
    function automatic logic [MAX_DIGITS-1:0] pos_to_onehot(input logic [MAX_POS_W-1:0] pos);
        logic [MAX_DIGITS-1:0] oh;
        oh = '0;
        for (int n = 0; n < MAX_DIGITS; n++) begin
            if (pos == MAX_POS_W'(3 * n)) oh[n] = 1'b1;
        end
        return oh;
    endfunction

    // Lowest set bit wins; an all-zero field maps to main cathode 0.
    function automatic logic [MAX_POS_W-1:0] onehot_to_pos(input logic [MAX_DIGITS-1:0] oh);
        logic [MAX_POS_W-1:0] pos;
        pos = '0;
        for (int n = MAX_DIGITS - 1; n >= 0; n--) begin
            if (oh[n]) pos = MAX_POS_W'(3 * n);
        end
        return pos;
    endfunction

endpackage

// File: rtl/dekatron_tube.sv
// One dekatron tube: glow position register with single-step and parallel load.
// Ports: clk, rst_n; step/dir move the glow one position, load/load_onehot
// jump straight to a main cathode; main_oh is the registered main-cathode
// one-hot (zero on guides), on_main flags a main cathode, wrap_c flags that a
// step taken now lands on the wrap digit (0 going right, DIGITS-1 going left).
// Optional (DEKATRON_BCD_OUT_EN): bcd, registered digit index of the glow.
module dekatron_tube
    import dekatron_pkg::*;
#(
    parameter int unsigned DIGITS = 10,
    parameter int unsigned POS_W  = $clog2(3 * DIGITS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic              dir,
    input  logic              load,
    input  logic [DIGITS-1:0] load_onehot,
    output logic [DIGITS-1:0] main_oh,
    output logic              on_main,
    output logic              wrap_c
`ifdef DEKATRON_BCD_OUT_EN
    ,
    output logic [$clog2(DIGITS)-1:0] bcd
`endif
);

    localparam int unsigned POS_LAST = 3 * DIGITS - 1;

    logic [POS_W-1:0]  pos_q, pos_d;
    logic [DIGITS-1:0] main_oh_q, main_oh_d;
    logic              on_main_q, on_main_d;

    // Next glow position: load jumps directly, steps wrap modulo 3*DIGITS.
    always_comb begin
        pos_d = pos_q;
        if (load) begin
            pos_d = POS_W'(onehot_to_pos(MAX_DIGITS'(load_onehot)));
        end else if (step) begin
            if (dir == DIR_RIGHT) begin
                pos_d = (pos_q == POS_W'(POS_LAST)) ? '0 : pos_q + POS_W'(1);
            end else begin
                pos_d = (pos_q == '0) ? POS_W'(POS_LAST) : pos_q - POS_W'(1);
            end
        end
    end

    always_comb begin
        main_oh_d = DIGITS'(pos_to_onehot(MAX_POS_W'(pos_d)));
        on_main_d = |main_oh_d;
    end

    // Landing onto 0 (right) comes from 3D-1; landing onto D-1 (left) from 3D-2.
    always_comb begin
        if (dir == DIR_LEFT) wrap_c = (pos_q == POS_W'(POS_LAST - 1));
        else                 wrap_c = (pos_q == POS_W'(POS_LAST));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q     <= '0;
            main_oh_q <= DIGITS'(1);
            on_main_q <= 1'b1;
        end else begin
            pos_q     <= pos_d;
            main_oh_q <= main_oh_d;
            on_main_q <= on_main_d;
        end
    end

    assign main_oh = main_oh_q;
    assign on_main = on_main_q;

`ifdef DEKATRON_BCD_OUT_EN
    localparam int unsigned BCD_W = $clog2(DIGITS);

    logic [BCD_W-1:0] bcd_q, bcd_d;

    // Digit index only refreshes when the glow reaches a main cathode.
    always_comb begin
        bcd_d = bcd_q;
        if ((load || step) && on_main_d) begin
            for (int n = 0; n < int'(DIGITS); n++) begin
                if (pos_d == POS_W'(3 * n)) bcd_d = BCD_W'(n);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bcd_q <= '0;
        else        bcd_q <= bcd_d;
    end

    assign bcd = bcd_q;
`endif

endmodule

// File: rtl/dekatron_counter.sv
// Chain of COUNT dekatron tubes with rippling carry/borrow (tube 0 = LSD).
// Ports: Clk, Rst_n (async, active-low); Request/Dir start a step and Set/In
// load all tubes, both sampled only while Ready; Out is the per-tube
// main-cathode one-hot; Ready marks idle; Overflow pulses when the last tube
// wraps. Optional macro DEKATRON_BCD_OUT_EN adds Bcd, the per-tube digit index.
module dekatron_counter
    import dekatron_pkg::*;
#(
    parameter int unsigned DIGITS = 10,
    parameter int unsigned COUNT  = 4
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    Request,
    input  logic                    Dir,
    input  logic                    Set,
    input  logic [COUNT*DIGITS-1:0] In,
    output logic [COUNT*DIGITS-1:0] Out,
    output logic                    Ready,
    output logic                    Overflow
`ifdef DEKATRON_BCD_OUT_EN
    ,
    output logic [COUNT*$clog2(DIGITS)-1:0] Bcd
`endif
);

    localparam int unsigned POS_W = $clog2(3 * DIGITS);
    localparam int unsigned ACT_W = (COUNT > 1) ? $clog2(COUNT) : 1;

    dek_state_e       state_q, state_d;
    logic [ACT_W-1:0] active_q, active_d;
    logic             dir_q, dir_d;
    logic             ready_q, ready_d;
    logic             overflow_q, overflow_d;

    logic [COUNT-1:0] step_c;
    logic [COUNT-1:0] on_main_c;
    logic [COUNT-1:0] wrap_vec_c;
    logic             wrap_sel_c;
    logic             last_c;
    logic             load_c;

    assign wrap_sel_c = wrap_vec_c[active_q];
    assign last_c     = (active_q == ACT_W'(COUNT - 1));

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            active_q   <= '0;
            dir_q      <= DIR_RIGHT;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            dir_q      <= dir_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
        end
    end

    // Next state: Set beats Request in IDLE; LAND ripples on carry/borrow.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        dir_d    = dir_q;
        case (state_q)
            IDLE: begin
                if (!Set && Request) begin
                    state_d  = G1;
                    active_d = '0;
                    dir_d    = Dir;
                end
            end
            G1:   state_d = G2;
            G2:   state_d = LAND;
            LAND: begin
                if (wrap_sel_c && !last_c) begin
                    active_d = active_q + ACT_W'(1);
                    state_d  = G1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: only the active tube steps while busy.
    always_comb begin
        step_c     = '0;
        load_c     = 1'b0;
        ready_d    = 1'b0;
        overflow_d = 1'b0;
        for (int k = 0; k < int'(COUNT); k++) begin
            step_c[k] = (state_q != IDLE) && (active_q == ACT_W'(k));
        end
        load_c     = (state_q == IDLE) && Set;
        ready_d    = (state_d == IDLE);
        overflow_d = (state_q == LAND) && wrap_sel_c && last_c;
    end

    for (genvar k = 0; k < COUNT; k++) begin : g_tube
        dekatron_tube #(
            .DIGITS (DIGITS),
            .POS_W  (POS_W)
        ) u_tube (
            .clk         (Clk),
            .rst_n       (Rst_n),
            .step        (step_c[k]),
            .dir         (dir_q),
            .load        (load_c),
            .load_onehot (In[k*DIGITS +: DIGITS]),
            .main_oh     (Out[k*DIGITS +: DIGITS]),
            .on_main     (on_main_c[k]),
            .wrap_c      (wrap_vec_c[k])
`ifdef DEKATRON_BCD_OUT_EN
            ,
            .bcd         (Bcd[k*$clog2(DIGITS) +: $clog2(DIGITS)])
`endif
        );
    end

    assign Ready    = ready_q & (&on_main_c);
    assign Overflow = overflow_q;

endmodule
